// File: rtl/ulpi_rx_packetizer.sv
// ULPI receive sniffer: tracks DIR turnaround and RxCMD, commits whole packets into data/info FIFOs.
// Define ULPI_RX_TIMESTAMP_EN to append a free-running TS_W timestamp to each info record.
module ulpi_rx_packetizer #(
  parameter int COUNT_W = 10,
  parameter int DATA_AW = 8,
  parameter int INFO_AW = 4,
  parameter int TS_W    = 16,
  parameter int DROP_W  = 8,
`ifdef ULPI_RX_TIMESTAMP_EN
  localparam int INFO_W = 11 + COUNT_W + TS_W
`else
  localparam int INFO_W = 11 + COUNT_W + 0 * TS_W
`endif
) (
  input  logic              clk_ULPI,
  input  logic              rst,
  input  logic              ReadAllow,
  output logic              busy,
  output logic [7:0]        RxCMD,
  input  logic              DATA_re,
  output logic [7:0]        USB_DATA,
  output logic              DATA_buff_empty,
  output logic              DATA_buff_full,
  input  logic              INFO_re,
  output logic [INFO_W-1:0] USB_INFO_DATA,
  output logic              INFO_buff_empty,
  output logic              INFO_buff_full,
  output logic [DROP_W-1:0] drop_count,
  input  logic              DIR,
  input  logic              NXT,
  input  logic [7:0]        DATA_I,
  output logic [7:0]        DATA_O,
  output logic              STP
);

  typedef enum logic [2:0] {IDLE, TURN, BUS, RECV, DROP, SKIP} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t              state_q;
  logic                dir_q;
  logic [7:0]          rxcmd_q, usb_data_q;
  logic [INFO_W-1:0]   info_data_q;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                host_disc_q, rx_err_q;
  logic [DATA_AW:0]    wr_spec_q, wr_commit_q, data_rd_q;
  logic [INFO_AW:0]    info_wr_q, info_rd_q;
  logic [7:0]          data_mem [2**DATA_AW];
  logic [INFO_W-1:0]   info_mem [2**INFO_AW];

  logic                is_cmd, pkt_end, data_we, info_we, rd_data, rd_info;
  logic                len_sat, rec_hd, rec_err;
  logic [7:0]          rec_cmd;
  logic [INFO_W-1:0]   record;

  assign is_cmd  = DIR & ~NXT;
  assign pkt_end = ~DIR | (is_cmd & ~DATA_I[4]);

  assign DATA_buff_empty = (wr_commit_q == data_rd_q);
  assign DATA_buff_full  = (wr_spec_q[DATA_AW] != data_rd_q[DATA_AW]) &&
                           (wr_spec_q[DATA_AW-1:0] == data_rd_q[DATA_AW-1:0]);
  assign INFO_buff_empty = (info_wr_q == info_rd_q);
  assign INFO_buff_full  = (info_wr_q[INFO_AW] != info_rd_q[INFO_AW]) &&
                           (info_wr_q[INFO_AW-1:0] == info_rd_q[INFO_AW-1:0]);

  assign data_we = DIR & NXT & ~DATA_buff_full &
                   (((state_q == BUS) & ReadAllow & ~INFO_buff_full) | (state_q == RECV));
  assign info_we = (state_q == RECV) & pkt_end;
  assign rd_data = DATA_re & ~DATA_buff_empty;
  assign rd_info = INFO_re & ~INFO_buff_empty;

  // The record reflects the RxCMD byte arriving on the terminating edge, not the stale one.
  assign rec_cmd = is_cmd ? DATA_I : rxcmd_q;
  assign rec_err = rx_err_q | (is_cmd & (DATA_I[5:4] == 2'b11));
  assign rec_hd  = host_disc_q | (is_cmd & (DATA_I[5:4] == 2'b10));
  assign len_sat = (count_q == CNT_MAX);
  assign count_d = len_sat ? count_q : count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  assign drop_d  = (drop_q == '1) ? drop_q : drop_q + {{(DROP_W-1){1'b0}}, 1'b1};

`ifdef ULPI_RX_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_lat_q;

  always_ff @(posedge clk_ULPI) begin
    if (rst) begin
      ts_q     <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_q <= ts_q + {{(TS_W-1){1'b0}}, 1'b1};
      if ((state_q == BUS) && data_we) ts_lat_q <= ts_q;
    end
  end

  assign record = {rec_cmd, len_sat, rec_hd, rec_err, count_q, ts_lat_q};
`else
  assign record = {rec_cmd, len_sat, rec_hd, rec_err, count_q};
`endif

  always_ff @(posedge clk_ULPI) begin
    if (data_we) data_mem[wr_spec_q[DATA_AW-1:0]] <= DATA_I;
    if (info_we) info_mem[info_wr_q[INFO_AW-1:0]] <= record;
  end

  always_ff @(posedge clk_ULPI) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= 1'b1;
      rxcmd_q     <= '0;
      usb_data_q  <= '0;
      info_data_q <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      host_disc_q <= 1'b0;
      rx_err_q    <= 1'b0;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      data_rd_q   <= '0;
      info_wr_q   <= '0;
      info_rd_q   <= '0;
    end else begin
      dir_q <= DIR;
      if (rd_data) begin
        usb_data_q <= data_mem[data_rd_q[DATA_AW-1:0]];
        data_rd_q  <= data_rd_q + {{DATA_AW{1'b0}}, 1'b1};
      end
      if (rd_info) begin
        info_data_q <= info_mem[info_rd_q[INFO_AW-1:0]];
        info_rd_q   <= info_rd_q + {{INFO_AW{1'b0}}, 1'b1};
      end
      if (data_we) wr_spec_q <= wr_spec_q + {{DATA_AW{1'b0}}, 1'b1};
      if (info_we) begin
        info_wr_q   <= info_wr_q + {{INFO_AW{1'b0}}, 1'b1};
        wr_commit_q <= wr_spec_q;
      end
      case (state_q)
        IDLE: if (DIR && !dir_q) state_q <= TURN;
        TURN: state_q <= DIR ? BUS : IDLE;
        BUS: begin
          if (!DIR)           state_q <= IDLE;
          else if (is_cmd)    rxcmd_q <= DATA_I;
          else if (!ReadAllow) state_q <= SKIP;
          else if (!data_we)  state_q <= DROP;
          else begin
            count_q     <= {{(COUNT_W-1){1'b0}}, 1'b1};
            host_disc_q <= 1'b0;
            rx_err_q    <= 1'b0;
            state_q     <= RECV;
          end
        end
        RECV: begin
          if (DIR && NXT) begin
            if (data_we) count_q <= count_d;
            else         state_q <= DROP;
          end
          if (is_cmd) begin
            rxcmd_q     <= DATA_I;
            host_disc_q <= rec_hd;
            rx_err_q    <= rec_err;
          end
          if (pkt_end) state_q <= DIR ? BUS : IDLE;
        end
        DROP, SKIP: begin
          if (is_cmd) rxcmd_q <= DATA_I;
          if (pkt_end) begin
            state_q <= DIR ? BUS : IDLE;
            if (state_q == DROP) begin
              wr_spec_q <= wr_commit_q;
              drop_q    <= drop_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign RxCMD         = rxcmd_q;
  assign USB_DATA      = usb_data_q;
  assign USB_INFO_DATA = info_data_q;
  assign drop_count    = drop_q;
  assign DATA_O        = 8'h00;
  assign STP           = 1'b0;

endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
// Randomized bench for ulpi_rx_packetizer: packet-level model of committed bytes, records and drops.
module tb_ulpi_rx_packetizer;
  localparam int COUNT_W = 3;
  localparam int DATA_AW = 4;
  localparam int INFO_AW = 2;
  localparam int TS_W    = 16;
  localparam int DROP_W  = 8;
`ifdef ULPI_RX_TIMESTAMP_EN
  localparam int TSB = TS_W;
`else
  localparam int TSB = 0;
`endif
  localparam int INFO_W = 11 + COUNT_W + TSB;
  localparam int DDEPTH = 1 << DATA_AW;
  localparam int IDEPTH = 1 << INFO_AW;
  localparam int CMAX   = (1 << COUNT_W) - 1;

  logic              clk_ULPI = 1'b0;
  logic              rst, ReadAllow, DATA_re, INFO_re, DIR, NXT;
  logic [7:0]        DATA_I, RxCMD, USB_DATA, DATA_O;
  logic              busy, DATA_buff_empty, DATA_buff_full, INFO_buff_empty, INFO_buff_full, STP;
  logic [INFO_W-1:0] USB_INFO_DATA;
  logic [DROP_W-1:0] drop_count;

  ulpi_rx_packetizer #(
    .COUNT_W(COUNT_W), .DATA_AW(DATA_AW), .INFO_AW(INFO_AW), .TS_W(TS_W), .DROP_W(DROP_W)
  ) dut (
    .clk_ULPI(clk_ULPI), .rst(rst), .ReadAllow(ReadAllow), .busy(busy), .RxCMD(RxCMD),
    .DATA_re(DATA_re), .USB_DATA(USB_DATA), .DATA_buff_empty(DATA_buff_empty),
    .DATA_buff_full(DATA_buff_full), .INFO_re(INFO_re), .USB_INFO_DATA(USB_INFO_DATA),
    .INFO_buff_empty(INFO_buff_empty), .INFO_buff_full(INFO_buff_full),
    .drop_count(drop_count), .DIR(DIR), .NXT(NXT), .DATA_I(DATA_I), .DATA_O(DATA_O), .STP(STP)
  );

  always #8 clk_ULPI = ~clk_ULPI;

  int n_chk = 0, n_pass = 0, cyc_n = 0;
  int exp_drop = 0;
  logic [7:0] pl_q[$];
  logic [7:0] exp_data[$];
  logic [INFO_W-TSB-1:0] exp_info[$];
  int exp_cyc[$];
  logic [7:0] last_cmd = 8'h00;
  logic [7:0] last_usb = 8'h00;
`ifdef ULPI_RX_TIMESTAMP_EN
  bit have_prev = 0;
  int prev_cyc = 0;
  logic [TS_W-1:0] prev_ts = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_ULPI);
    cyc_n++;
    #1;
  endtask

  task automatic bus(input logic d, input logic n, input logic [7:0] x);
    DIR = d; NXT = n; DATA_I = x;
    tick();
  endtask

  task automatic mk(input int n);
    pl_q.delete();
    for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom));
  endtask

  // mid_mode: 0 none, 1 random RxCMDs, 2 force 0x3D after the first byte
  task automatic send_pkt(input bit allow, input int mid_mode, input bit end_dir, input logic [7:0] end_cmd);
    int n;
    int c0;
    bit err, hd, do_mid;
    logic [7:0] mc;
    logic [COUNT_W-1:0] cnt;
    n = pl_q.size(); err = 0; hd = 0; c0 = 0;
    bus(1, 0, 8'hAA);
    bus(1, 1, 8'hAA);
    bus(1, 0, 8'h1D); last_cmd = 8'h1D;
    ReadAllow = allow;
    for (int i = 0; i < n; i++) begin
      bus(1, 1, pl_q[i]);
      if (i == 0) begin
        c0 = cyc_n;
        ReadAllow = 1'($urandom);
      end
      if (i < n - 1) begin
        do_mid = (mid_mode == 2 && i == 0) || (mid_mode == 1 && $urandom_range(0, 2) == 0);
        if (do_mid) begin
          mc = (mid_mode == 2 || $urandom_range(0, 3) == 0) ? 8'h3D : 8'h1D;
          bus(1, 0, mc);
          last_cmd = mc;
          if (mc[5:4] == 2'b11) err = 1;
        end
      end
    end
    if (end_dir) bus(0, 0, 8'h55);
    else begin
      bus(1, 0, end_cmd);
      last_cmd = end_cmd;
      hd = (end_cmd[5:4] == 2'b10);
      bus(0, 0, 8'h00);
    end
    bus(0, 0, 8'h00);
    ReadAllow = 1;
    if (allow) begin
      if (exp_info.size() == IDEPTH || n > DDEPTH - exp_data.size()) begin
        if (exp_drop < 255) exp_drop++;
      end else begin
        foreach (pl_q[i]) exp_data.push_back(pl_q[i]);
        cnt = COUNT_W'((n > CMAX) ? CMAX : n);
        exp_info.push_back({last_cmd, (n >= CMAX), hd, err, cnt});
        exp_cyc.push_back(c0);
      end
    end
    chk("rxcmd", RxCMD, last_cmd);
    chk("drop_count", drop_count, exp_drop);
    chk("busy_idle", busy, 0);
    chk("data_empty", DATA_buff_empty, exp_data.size() == 0);
    chk("data_full", DATA_buff_full, exp_data.size() == DDEPTH);
    chk("info_empty", INFO_buff_empty, exp_info.size() == 0);
    chk("info_full", INFO_buff_full, exp_info.size() == IDEPTH);
  endtask

  task automatic drain_data();
    while (exp_data.size() > 0) begin
      DATA_re = 1; tick(); DATA_re = 0;
      last_usb = exp_data.pop_front();
      chk("usb_data", USB_DATA, last_usb);
    end
    DATA_re = 1; tick(); DATA_re = 0;
    chk("usb_data_hold", USB_DATA, last_usb);
    chk("data_empty_drained", DATA_buff_empty, 1);
  endtask

  task automatic drain_info();
    logic [INFO_W-TSB-1:0] e;
    int c;
`ifdef ULPI_RX_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
    while (exp_info.size() > 0) begin
      INFO_re = 1; tick(); INFO_re = 0;
      e = exp_info.pop_front();
      c = exp_cyc.pop_front();
      chk("info_record", USB_INFO_DATA[INFO_W-1:TSB], e);
`ifdef ULPI_RX_TIMESTAMP_EN
      ts = USB_INFO_DATA[TSB-1:0];
      if (have_prev) chk("ts_delta", TS_W'(ts - prev_ts), TS_W'(c - prev_cyc));
      have_prev = 1; prev_ts = ts; prev_cyc = c;
`endif
    end
    INFO_re = 1; tick(); INFO_re = 0;
    chk("info_empty_drained", INFO_buff_empty, 1);
  endtask

  task automatic drain_all();
    drain_data();
    drain_info();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; DIR = 0; NXT = 0; DATA_I = 0; ReadAllow = 1; DATA_re = 0; INFO_re = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_rxcmd", RxCMD, 0);
    chk("rst_usb_data", USB_DATA, 0);
    chk("rst_usb_info", USB_INFO_DATA, 0);
    chk("rst_data_empty", DATA_buff_empty, 1);
    chk("rst_data_full", DATA_buff_full, 0);
    chk("rst_info_empty", INFO_buff_empty, 1);
    chk("rst_info_full", INFO_buff_full, 0);
    chk("rst_drop", drop_count, 0);
    chk("data_o", DATA_O, 0);
    chk("stp", STP, 0);
    rst = 0;
    tick();

    pl_q = {8'h11, 8'h22, 8'h33};
    send_pkt(1, 0, 0, 8'h0D);
    drain_all();

    mk(DDEPTH + 4);
    send_pkt(1, 0, 0, 8'h0D);
    mk(2);
    send_pkt(1, 0, 0, 8'h0D);
    drain_all();

    mk(4);
    send_pkt(0, 0, 0, 8'h0D);
    mk(4);
    send_pkt(1, 0, 0, 8'h0D);
    drain_all();

    mk(3);
    send_pkt(1, 2, 1, 8'h00);
    drain_all();

    mk(10);
    send_pkt(1, 0, 0, 8'h2D);
    mk(CMAX);
    send_pkt(1, 0, 1, 8'h00);
    drain_all();

    mk(DDEPTH);
    send_pkt(1, 0, 0, 8'h0D);
    mk(1);
    send_pkt(1, 0, 0, 8'h0D);
    drain_all();

    for (int k = 0; k < IDEPTH + 1; k++) begin
      mk(1);
      send_pkt(1, 0, 0, 8'h0D);
    end
    drain_all();

    mk(2);
    send_pkt(1, 0, 0, 8'h0D);
    repeat (100) tick();
    mk(2);
    send_pkt(1, 0, 1, 8'h00);
    drain_all();

    for (int k = 0; k < 30; k++) begin
      mk($urandom_range(1, 12));
      send_pkt($urandom_range(0, 5) != 0, 1, 1'($urandom), ($urandom_range(0, 1) == 1) ? 8'h2D : 8'h0D);
      if ($urandom_range(0, 2) == 0) drain_all();
    end
    drain_all();

    bus(1, 0, 8'hAA); bus(1, 1, 8'hAA); bus(1, 0, 8'h1D);
    bus(1, 1, 8'h01); bus(1, 1, 8'h02);
    rst = 1;
    bus(1, 1, 8'h03);
    rst = 0;
    exp_data.delete(); exp_info.delete(); exp_cyc.delete();
    exp_drop = 0; last_cmd = 8'h00; last_usb = 8'h00;
`ifdef ULPI_RX_TIMESTAMP_EN
    have_prev = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus(1, i[0], 8'(8'h40 + i));
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_empty", DATA_buff_empty, 1);
      chk("rst_mid_info_empty", INFO_buff_empty, 1);
    end
    bus(1, 0, 8'h0D);
    chk("rst_mid_rxcmd", RxCMD, 0);
    chk("rst_mid_usb", USB_DATA, 0);
    bus(0, 0, 8'h00);
    bus(0, 0, 8'h00);
    mk(3);
    send_pkt(1, 1, 0, 8'h0D);
    drain_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
